// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one MIPS instruction with its rs/rt values, decodes it
// into an ALU func code and operands, drives the registered ALU, waits ALU_LAT
// edges, captures the result/zero flag and hands them downstream.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The sender holds valid and payload until that edge. The receiver may
// raise or lower ready freely. in_ready is high only in IDLE. res_valid is high
// only in DONE, where all res_* stay stable until res_ready is seen.
module alu_issue_ctrl #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  output logic [5:0]  alu_func,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_zero,
  output logic        res_is_br,
  output logic        res_illegal
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  // Index of the ISSUE cycle whose closing edge samples the ALU result.
  localparam logic [2:0] LAST_WAIT = 3'(ALU_LAT - 1);

  state_t      state;
  state_t      state_nx;
  logic [2:0]  wait_cnt;

  logic        accept;
  logic        capture;

  logic        dec_legal;
  logic        dec_br;
  logic [5:0]  dec_func;
  logic [31:0] dec_b;

  // The rs register field is never needed: its value arrives on in_rs_val.
  logic        unused_rs_field;
  assign unused_rs_field = ^in_instr[25:21];

  assign in_ready  = (state == IDLE);
  assign res_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign capture   = (state == ISSUE) && (wait_cnt == LAST_WAIT);

  // Instruction decode: func code, second operand, branch and legality flags.
  always_comb begin
    dec_legal = 1'b0;
    dec_br    = 1'b0;
    dec_func  = 6'd0;
    dec_b     = 32'd0;
    if (in_instr[31:26] == 6'b000000) begin
      dec_func = in_instr[5:0];
      dec_b    = in_rt_val;
      case (in_instr[5:0])
        6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
        6'b011000, 6'b011010, 6'b100001, 6'b100010, 6'b100011,
        6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010: dec_legal = 1'b1;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      case (in_instr[31:26])
        6'b000100: begin dec_legal = 1'b1; dec_br = 1'b1; dec_func = 6'b111000; dec_b = in_rt_val; end
        6'b000101: begin dec_legal = 1'b1; dec_br = 1'b1; dec_func = 6'b111001; dec_b = in_rt_val; end
        6'b000110: begin dec_legal = 1'b1; dec_br = 1'b1; dec_func = 6'b111010; end
        6'b000111: begin dec_legal = 1'b1; dec_br = 1'b1; dec_func = 6'b111011; end
        6'b000001: begin
          if (in_instr[20:16] == 5'b00001) begin
            dec_legal = 1'b1;
            dec_br    = 1'b1;
            dec_func  = 6'b111100;
          end
        end
        6'b001111: begin dec_legal = 1'b1; dec_func = 6'b111101; dec_b = {16'd0, in_instr[15:0]}; end
        6'b001001: begin dec_legal = 1'b1; dec_func = 6'b100001; dec_b = {{16{in_instr[15]}}, in_instr[15:0]}; end
        6'b001010: begin dec_legal = 1'b1; dec_func = 6'b101010; dec_b = {{16{in_instr[15]}}, in_instr[15:0]}; end
        6'b001100: begin dec_legal = 1'b1; dec_func = 6'b100100; dec_b = {16'd0, in_instr[15:0]}; end
        6'b001101: begin dec_legal = 1'b1; dec_func = 6'b100101; dec_b = {16'd0, in_instr[15:0]}; end
        6'b001110: begin dec_legal = 1'b1; dec_func = 6'b100110; dec_b = {16'd0, in_instr[15:0]}; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // Next-state logic: illegal instructions skip the ALU and report at once.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = dec_legal ? ISSUE : DONE;
      ISSUE:   if (capture) state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, ALU drive registers, wait counter and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 3'd0;
      alu_func    <= 6'd0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      res_data    <= 32'd0;
      res_zero    <= 1'b0;
      res_is_br   <= 1'b0;
      res_illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        wait_cnt    <= 3'd0;
        res_data    <= 32'd0;
        res_zero    <= 1'b0;
        res_is_br   <= dec_br;
        res_illegal <= !dec_legal;
        if (dec_legal) begin
          alu_func <= dec_func;
          alu_a    <= in_rs_val;
          alu_b    <= dec_b;
        end
      end
      if (state == ISSUE) begin
        if (capture) begin
          res_data <= alu_out;
          res_zero <= alu_zero;
          wait_cnt <= 3'd0;
        end else begin
          wait_cnt <= wait_cnt + 3'd1;
        end
      end
    end
  end

endmodule
